// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input stream multiplexer with round-robin or fixed-priority
// arbitration feeding a single registered output slot.
module stream_mux_rr #(
    parameter  int W  = 4,
    parameter  int N  = 4,
    parameter  int RR = 1,
    localparam int SW = (N > 2) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    data_q, data_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [SW-1:0]   ptr_q, ptr_d;

    logic [W-1:0]    chan [N];
    logic [SW-1:0]   grant;
    logic [SW-1:0]   grant_next;
    logic [W-1:0]    grant_data;
    logic            any_valid;
    logic            ld;
    logic            in_xfer;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign chan[gi] = in_data[gi*W +: W];
    end

    // Pick the first valid channel at or above the pointer, wrapping past N-1.
    // With fixed priority the pointer never leaves 0, so this is lowest-index-first.
    always_comb begin : grant_search
        int unsigned cand;
        logic [SW-1:0] idx;
        grant     = '0;
        any_valid = 1'b0;
        cand      = 0;
        idx       = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            idx = SW'(cand);
            if (!any_valid && in_valid[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

    assign grant_data = chan[grant];
    assign grant_next = (grant == SW'(N - 1)) ? '0 : grant + 1'b1;
    assign ld         = (state_q == EMPTY) || out_ready;
    assign in_xfer    = any_valid && ld;

    // One-hot ready to the granted channel; held low while in reset.
    always_comb begin
        in_ready = '0;
        if (in_xfer && rst_n) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Output slot next-state: reload on any load opportunity, drain to EMPTY when idle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            EMPTY: begin
                if (any_valid) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready && !any_valid) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (in_xfer) begin
            data_d = grant_data;
            sel_d  = grant;
            if (RR != 0) begin
                ptr_d = grant_next;
            end
        end
    end

    // State, output word and arbitration pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr: one round-robin and one fixed-priority instance,
// each with a reference model and expected-word queue.
module tb_stream_mux_rr;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int SW = 2;

    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
    } word_t;

    typedef struct {
        bit             rst;
        int             dut;
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        logic           rdy;
        logic [N-1:0]   e_ir;
        logic           e_ov;
        logic [W-1:0]   e_od;
        logic [SW-1:0]  e_os;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           ordy;
    logic [N-1:0]   iv [2];
    logic [N*W-1:0] id [2];
    logic [N-1:0]   ir [2];
    logic [W-1:0]   od [2];
    logic           ov [2];
    logic [SW-1:0]  os [2];

    int             checks = 0;
    int             errors = 0;
    word_t          q0[$];
    word_t          q1[$];
    int             mptr = 0;
    int             gap_cnt [N];
    vec_t           tbl[$];

    always #5 clk = ~clk;

    stream_mux_rr #(.W(W), .N(N), .RR(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .in_data(id[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy), .out_sel(os[0])
    );

    stream_mux_rr #(.W(W), .N(N), .RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .in_data(id[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy), .out_sel(os[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int k, input word_t w);
        if (k == 0) q0.push_back(w);
        else        q1.push_back(w);
    endtask

    task automatic qpop(input int k, output word_t w);
        if (k == 0) w = q0.pop_front();
        else        w = q1.pop_front();
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        mptr = 0;
        for (int c = 0; c < N; c++) gap_cnt[c] = 0;
    endtask

    // k=0: round-robin from the model pointer; k=1: lowest index first.
    function automatic int model_grant(input int k, input logic [N-1:0] v);
        int start;
        int c;
        start = (k == 0) ? mptr : 0;
        for (int o = 0; o < N; o++) begin
            c = (start + o) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic cycle(input logic [N-1:0] v0, input logic [N*W-1:0] d0,
                         input logic [N-1:0] v1, input logic [N*W-1:0] d1,
                         input logic rdy,
                         output logic [N-1:0] irs0, output logic [N-1:0] irs1,
                         output int tg0, output int tg1);
        logic [N-1:0]   v;
        logic [N-1:0]   exp_ir;
        logic [N*W-1:0] d;
        int             g;
        bit             full;
        bit             ld;
        word_t          w;
        word_t          nw;
        iv[0] = v0; id[0] = d0;
        iv[1] = v1; id[1] = d1;
        ordy  = rdy;
        @(negedge clk);
        irs0 = ir[0];
        irs1 = ir[1];
        tg0  = -1;
        tg1  = -1;
        for (int k = 0; k < 2; k++) begin
            v    = (k == 0) ? v0 : v1;
            d    = (k == 0) ? d0 : d1;
            full = (qsize(k) != 0);
            ld   = !full || rdy;
            g    = model_grant(k, v);
            exp_ir = '0;
            if (g >= 0 && ld) exp_ir[g] = 1'b1;
            check((k == 0) ? "in_ready_rr" : "in_ready_fp", 32'(ir[k]), 32'(exp_ir));
            check((k == 0) ? "out_valid_rr" : "out_valid_fp", 32'(ov[k]), 32'(full));
            if (full && rdy) begin
                qpop(k, w);
                check((k == 0) ? "out_data_rr" : "out_data_fp", 32'(od[k]), 32'(w.d));
                check((k == 0) ? "out_sel_rr" : "out_sel_fp", 32'(os[k]), 32'(w.s));
            end
            if (g >= 0 && ld) begin
                nw.d = d[g*W +: W];
                nw.s = g[SW-1:0];
                qpush(k, nw);
                if (k == 0) begin
                    for (int c = 0; c < N; c++) begin
                        if (v[c] && c != g) begin
                            gap_cnt[c]++;
                            checks++;
                            if (gap_cnt[c] > N - 1) begin
                                errors++;
                                $display("FAIL grant_gap ch%0d: waited %0d grants, limit %0d", c, gap_cnt[c], N - 1);
                            end
                        end else begin
                            gap_cnt[c] = 0;
                        end
                    end
                    mptr = (g + 1) % N;
                    tg0  = g;
                end else begin
                    tg1 = g;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check((k == 0) ? "out_valid_post_rr" : "out_valid_post_fp", 32'(ov[k]), 32'(qsize(k) != 0));
        end
    endtask

    task automatic do_reset(input logic [N-1:0] v);
        rst_n = 1'b0;
        iv[0] = v; iv[1] = v;
        id[0] = '1; id[1] = '1;
        ordy  = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_out_valid", 32'(ov[k]), 0);
            check("rst_in_ready", 32'(ir[k]), 0);
            check("rst_out_data", 32'(od[k]), 0);
            check("rst_out_sel", 32'(os[k]), 0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_edge_in_ready", 32'(ir[k]), 0);
            check("rst_edge_out_valid", 32'(ov[k]), 0);
        end
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic add(input bit rst, input int dut, input logic [N-1:0] v,
                       input logic [N*W-1:0] d, input logic rdy, input logic [N-1:0] e_ir,
                       input logic e_ov, input logic [W-1:0] e_od, input logic [SW-1:0] e_os);
        vec_t r;
        r.rst = rst; r.dut = dut; r.v = v; r.d = d; r.rdy = rdy;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od; r.e_os = e_os;
        tbl.push_back(r);
    endtask

    initial begin
        logic [N-1:0]   irs0, irs1;
        logic [N-1:0]   irk;
        int             g0, g1;
        int             k;
        logic [N-1:0]   pv [2];
        logic [N*W-1:0] pd [2];
        logic           rdy;

        // Round-robin rotation out of reset with all channels valid.
        add(1, 0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 4'h1, 2'd0);
        add(0, 0, 4'b1111, 16'h4321, 1, 4'b0010, 1, 4'h2, 2'd1);
        add(0, 0, 4'b1111, 16'h4321, 1, 4'b0100, 1, 4'h3, 2'd2);
        add(0, 0, 4'b1111, 16'h4321, 1, 4'b1000, 1, 4'h4, 2'd3);
        add(0, 0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 4'h1, 2'd0);
        // Fixed priority: channel 1 always beats channel 3.
        add(1, 1, 4'b1010, 16'h7050, 1, 4'b0010, 1, 4'h5, 2'd1);
        add(0, 1, 4'b1010, 16'h7050, 1, 4'b0010, 1, 4'h5, 2'd1);
        add(0, 1, 4'b1010, 16'h7050, 1, 4'b0010, 1, 4'h5, 2'd1);
        // Backpressure for 5 cycles, then drain one word per cycle.
        add(1, 0, 4'b1111, 16'hDCBA, 0, 4'b0001, 1, 4'hA, 2'd0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 4'b1110, 16'hDCBA, 0, 4'b0000, 1, 4'hA, 2'd0);
        add(0, 0, 4'b1110, 16'hDCBA, 1, 4'b0010, 1, 4'hB, 2'd1);
        add(0, 0, 4'b1100, 16'hDCBA, 1, 4'b0100, 1, 4'hC, 2'd2);
        add(0, 0, 4'b1000, 16'hDCBA, 1, 4'b1000, 1, 4'hD, 2'd3);
        add(0, 0, 4'b0000, 16'hDCBA, 1, 4'b0000, 0, 4'hD, 2'd3);
        // Single channel 2, then idle.
        add(0, 0, 4'b0100, 16'h0900, 1, 4'b0100, 1, 4'h9, 2'd2);
        add(0, 0, 4'b0000, 16'h0900, 1, 4'b0000, 0, 4'h9, 2'd2);

        for (int c = 0; c < N; c++) gap_cnt[c] = 0;
        iv[0] = '0; iv[1] = '0; id[0] = '0; id[1] = '0; ordy = 1'b0;
        #2;
        do_reset(4'b1111);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset(tbl[i].v);
            cycle(tbl[i].v, tbl[i].d, tbl[i].v, tbl[i].d, tbl[i].rdy, irs0, irs1, g0, g1);
            k   = tbl[i].dut;
            irk = (k == 0) ? irs0 : irs1;
            check($sformatf("tbl%0d_in_ready", i), 32'(irk), 32'(tbl[i].e_ir));
            check($sformatf("tbl%0d_out_valid", i), 32'(ov[k]), 32'(tbl[i].e_ov));
            check($sformatf("tbl%0d_out_data", i), 32'(od[k]), 32'(tbl[i].e_od));
            check($sformatf("tbl%0d_out_sel", i), 32'(os[k]), 32'(tbl[i].e_os));
        end

        // Mid-cycle reset while FULL with the pointer away from 0.
        cycle(4'b0010, 16'h0050, 4'b0010, 16'h0050, 1, irs0, irs1, g0, g1);
        cycle(4'b1111, 16'h4321, 4'b1111, 16'h4321, 0, irs0, irs1, g0, g1);
        check("bp_in_ready", 32'(irs0), 0);
        check("bp_hold_data", 32'(od[0]), 32'h5);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(ov[0]), 0);
        check("async_rst_out_data", 32'(od[0]), 0);
        check("async_rst_out_sel", 32'(os[0]), 0);
        check("async_rst_in_ready", 32'(ir[0]), 0);
        #1 rst_n = 1'b1;
        clear_model();
        cycle(4'b1111, 16'h4321, 4'b1111, 16'h4321, 1, irs0, irs1, g0, g1);
        check("post_rst_grant", 32'(irs0), 32'b0001);
        check("post_rst_out_sel", 32'(os[0]), 0);
        check("post_rst_out_data", 32'(od[0]), 32'h1);

        // Random traffic; a channel's word stays offered until taken.
        pv[0] = '0; pv[1] = '0; pd[0] = '0; pd[1] = '0;
        for (int t = 0; t < 10000; t++) begin
            for (int kk = 0; kk < 2; kk++) begin
                for (int c = 0; c < N; c++) begin
                    if (!pv[kk][c] && $urandom_range(0, 2) != 0) begin
                        pv[kk][c] = 1'b1;
                        pd[kk][c*W +: W] = W'($urandom);
                    end
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            cycle(pv[0], pd[0], pv[1], pd[1], rdy, irs0, irs1, g0, g1);
            if (g0 >= 0) pv[0][g0] = 1'b0;
            if (g1 >= 0) pv[1][g1] = 1'b0;
        end

        for (int t = 0; t < 3; t++)
            cycle('0, '0, '0, '0, 1, irs0, irs1, g0, g1);
        check("drained_rr", 32'(q0.size()), 0);
        check("drained_fp", 32'(q1.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter W, default 4: data width of each channel in bits, W >= 1.
REQ-002 Parameter N, default 4: number of input channels, N >= 2.
REQ-003 Parameter RR, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, lowest index first.
REQ-004 Derived SW = max(1, clog2(N)): width of the channel-index fields.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port in_data, input, N*W bits: channel i occupies bits [i*W+W-1 : i*W].
REQ-008 Port in_valid, input, N bits: bit i high means channel i offers a word.
REQ-009 Port in_ready, output, N bits: bit i high means channel i's word is accepted this cycle.
REQ-010 Port out_data, output, W bits: registered output word.
REQ-011 Port out_valid, output, 1 bit: out_data holds a word not yet taken.
REQ-012 Port out_ready, input, 1 bit: the downstream sink accepts out_data this cycle.
REQ-013 Port out_sel, output, SW bits: index of the channel that supplied out_data.

Function
REQ-014 The output stage SHALL be a one-entry register with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 Load enable SHALL be ld = !out_valid || out_ready.
REQ-016 A transfer on channel i SHALL occur when in_valid[i] && in_ready[i] are both high at a clock edge.
REQ-017 An output transfer SHALL occur when out_valid && out_ready are both high at a clock edge.
REQ-018 Exactly one channel, the grant g, SHALL be chosen combinationally each cycle from the channels with in_valid high.
REQ-019 in_ready SHALL be one-hot: in_ready[g] = ld when any in_valid bit is high; in_ready SHALL be all zeros otherwise.
REQ-020 in_ready SHALL NOT depend on in_data.
REQ-021 When RR=0, g SHALL be the lowest index i with in_valid[i] high.
REQ-022 When RR=1, g SHALL be the first channel with in_valid high, searching upward from pointer p and wrapping from N-1 to 0.
REQ-023 When RR=1, p SHALL update to (g+1) mod N only on an input transfer; p SHALL hold otherwise.
REQ-024 When RR=0, p SHALL be unused and remain 0.
REQ-025 On an input transfer, the edge SHALL load out_data <= channel g's data, out_sel <= g and out_valid <= 1.
REQ-026 Latency SHALL be one cycle: a word accepted at edge k is visible on out_data after edge k.
REQ-027 When ld=1 and no channel is valid, out_valid SHALL clear to 0 at the edge; out_data and out_sel SHALL hold.
REQ-028 Backpressure: while out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold, and in_ready SHALL be all zeros.
REQ-029 Simultaneous output transfer and input transfer in one cycle SHALL reload the register with no bubble, sustaining one word per cycle.
REQ-030 A channel SHALL be granted again only after every other continuously valid channel has been granted once (RR=1).
REQ-031 out_valid, out_data and out_sel SHALL be driven directly from flops.
REQ-032 The block SHALL NOT drop or duplicate any word.

Reset
REQ-033 While rst_n=0, the block SHALL immediately force out_valid=0, out_data=0, out_sel=0 and p=0, without waiting for a clock edge.
REQ-034 While rst_n=0, in_ready SHALL be all zeros.
REQ-035 Assertion of rst_n mid-transfer SHALL discard the held word.
REQ-036 The first edge after rst_n deasserts SHALL accept input normally.

Verification (W=4, N=4)
REQ-037 Bench SHALL cover: reset with in_valid=1111 and out_ready=1 -> in_ready=0000, out_valid=0; after release, grants SHALL follow channels 0,1,2,3,0 on consecutive cycles with out_sel matching.
REQ-038 Bench SHALL cover: RR=0 with in_valid=1010 held for 3 cycles -> channel 1 is granted every cycle, and channel 3 is never granted.
REQ-039 Bench SHALL cover: words A,B,C,D on channels 0-3 and out_ready=0 for 5 cycles -> out_data=A and out_sel=0 are stable, and in_ready=0000 after the first load; when out_ready rises, the remaining words follow one per cycle.
REQ-040 Bench SHALL cover: single channel 2 valid with data 0x9 and out_ready=1 -> out_data=0x9 and out_sel=2 one cycle later; when in_valid drops, out_valid=0 the following cycle.
REQ-041 Bench SHALL cover: rst_n pulsed low between clock edges while FULL -> out_valid=0 asynchronously, and p=0 so the next grant restarts at channel 0.
REQ-042 Bench SHALL cover: random valid and ready, 10k cycles, with a scoreboard per channel -> in-order, lossless delivery and a grant gap of at most N-1 for a continuously valid channel (RR=1).
